// File: rtl/pulpemu_rst_gen.sv
// Sequenced reset generator for the FPGA emulation top: merges board reset, clock lock,
// a debounced external pin and a software request, then releases NUM_RST domains in order.
module pulpemu_rst_gen #(
  parameter int NUM_RST         = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 256,
  parameter int STAGGER_CYCLES  = 16
) (
  input  logic               ref_clk,
  input  logic               pad_reset,
  input  logic               locked_i,
  input  logic               ext_rst_i,
  input  logic               sw_rst_req_i,
  input  logic               cause_clr_i,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               rst_done_o,
  output logic [3:0]         rst_cause_o
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   lock_s;
  logic                   ext_s;
  logic                   lock_q;
  logic                   ext_db;
  logic [DB_W-1:0]        db_cnt;
  logic [CNT_W-1:0]       cnt;
  logic                   evt;
  logic [3:0]             cause_set;
  logic [NUM_RST-1:0]     rst_n_next;

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign ext_s  = ext_sync[SYNC_STAGES-1];

  // NOTE: every clocked block uses non-blocking assignments so all flops update together.
  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      lock_sync <= '0;
      ext_sync  <= '0;
      lock_q    <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_rst_i};
      lock_q    <= lock_s;
    end
  end

  // The debounced value only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      db_cnt <= '0;
      ext_db <= 1'b0;
    end else if (ext_s != ext_db) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        ext_db <= ext_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign evt = !lock_s | ext_db | sw_rst_req_i;

  // Domains come out of reset by shifting ones in from bit 0.
  assign rst_n_next = (rst_n_o << 1) | NUM_RST'(1);

  // While parked in WAIT_LOCK only a fresh lock drop is recorded, so power-up stays a pad cause.
  // NOTE: a default assignment first keeps this combinational block free of latches.
  always_comb begin
    cause_set = 4'b0000;
    if (state != WAIT_LOCK) begin
      cause_set = {sw_rst_req_i, ext_db, !lock_s, 1'b0};
    end else begin
      cause_set[1] = lock_q & !lock_s;
    end
  end

  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      rst_cause_o <= 4'b0001;
    end else begin
      rst_cause_o <= cause_set | (cause_clr_i ? 4'b0000 : rst_cause_o);
    end
  end

  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      rst_n_o    <= '0;
      rst_done_o <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          rst_n_o    <= '0;
          rst_done_o <= 1'b0;
          if (!evt) begin
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (evt) begin
            state <= WAIT_LOCK;
          end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt     <= '0;
            rst_n_o <= rst_n_next;
            if (&rst_n_next) begin
              rst_done_o <= 1'b1;
              state      <= RUN;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (evt) begin
            rst_n_o    <= '0;
            rst_done_o <= 1'b0;
            state      <= WAIT_LOCK;
          end else if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
            cnt     <= '0;
            rst_n_o <= rst_n_next;
            if (&rst_n_next) begin
              rst_done_o <= 1'b1;
              state      <= RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (evt) begin
            rst_n_o    <= '0;
            rst_done_o <= 1'b0;
            state      <= WAIT_LOCK;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_pulpemu_rst_gen.sv
// Directed bench for pulpemu_rst_gen: default build plus NUM_RST=1 and NUM_RST=8 builds
// sharing one clock and one set of inputs.
`timescale 1ns/1ps
module tb_pulpemu_rst_gen;

  logic       ref_clk = 1'b0;
  logic       pad_reset;
  logic       locked_i;
  logic       ext_rst_i;
  logic       sw_rst_req_i;
  logic       cause_clr_i;
  logic [2:0] rst_n_a;
  logic       done_a;
  logic [3:0] cause_a;
  logic [0:0] rst_n_b;
  logic       done_b;
  logic [3:0] cause_b;
  logic [7:0] rst_n_c;
  logic       done_c;
  logic [3:0] cause_c;

  int n_tests  = 0;
  int n_fail   = 0;
  int cur_edge = 0;

  always #5 ref_clk = ~ref_clk;

  pulpemu_rst_gen dut (
    .ref_clk(ref_clk), .pad_reset(pad_reset), .locked_i(locked_i), .ext_rst_i(ext_rst_i),
    .sw_rst_req_i(sw_rst_req_i), .cause_clr_i(cause_clr_i),
    .rst_n_o(rst_n_a), .rst_done_o(done_a), .rst_cause_o(cause_a)
  );

  pulpemu_rst_gen #(
    .NUM_RST(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .STAGGER_CYCLES(2)
  ) dut_one (
    .ref_clk(ref_clk), .pad_reset(pad_reset), .locked_i(locked_i), .ext_rst_i(ext_rst_i),
    .sw_rst_req_i(sw_rst_req_i), .cause_clr_i(cause_clr_i),
    .rst_n_o(rst_n_b), .rst_done_o(done_b), .rst_cause_o(cause_b)
  );

  pulpemu_rst_gen #(
    .NUM_RST(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(4), .STAGGER_CYCLES(3)
  ) dut_eight (
    .ref_clk(ref_clk), .pad_reset(pad_reset), .locked_i(locked_i), .ext_rst_i(ext_rst_i),
    .sw_rst_req_i(sw_rst_req_i), .cause_clr_i(cause_clr_i),
    .rst_n_o(rst_n_c), .rst_done_o(done_c), .rst_cause_o(cause_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cur_edge);
    end
  endtask

  // Advance to an absolute edge count and sample 1 ns after it.
  task automatic goto_edge(input int target);
    while (cur_edge < target) begin
      @(posedge ref_clk);
      cur_edge++;
    end
    #1;
  endtask

  task automatic main_release_seq(input string tag);
    goto_edge(258); check({tag, "_258"}, rst_n_a, 3'b000);
    goto_edge(259); check({tag, "_259"}, rst_n_a, 3'b001);
    goto_edge(274); check({tag, "_274"}, rst_n_a, 3'b001);
    goto_edge(275); check({tag, "_275"}, rst_n_a, 3'b011);
    goto_edge(290); check({tag, "_290"}, {rst_n_a, done_a}, {3'b011, 1'b0});
    goto_edge(291); check({tag, "_291"}, {rst_n_a, done_a}, {3'b111, 1'b1});
  endtask

  initial begin
    pad_reset    = 1'b0;
    locked_i     = 1'b1;
    ext_rst_i    = 1'b0;
    sw_rst_req_i = 1'b0;
    cause_clr_i  = 1'b0;
    #1 pad_reset = 1'b1;
    #1;
    check("reset_rst_n", rst_n_a, 3'b000);
    check("reset_done", done_a, 1'b0);
    check("reset_cause", cause_a, 4'b0001);
    repeat (3) @(posedge ref_clk);

    // Power-on with defaults.
    @(negedge ref_clk); pad_reset = 1'b0; cur_edge = 0;
    main_release_seq("por");
    check("por_cause", cause_a, 4'b0001);

    // Software request while running, then clear the cause.
    sw_rst_req_i = 1'b1;
    goto_edge(292);
    sw_rst_req_i = 1'b0;
    check("sw_rst_n", {rst_n_a, done_a}, {3'b000, 1'b0});
    check("sw_cause", cause_a, 4'b1001);
    cause_clr_i = 1'b1;
    goto_edge(293);
    cause_clr_i = 1'b0;
    check("sw_clr", cause_a, 4'b0000);
    goto_edge(548); check("sw_548", rst_n_a, 3'b000);
    goto_edge(549); check("sw_549", rst_n_a, 3'b001);
    goto_edge(581); check("sw_581", {rst_n_a, done_a}, {3'b111, 1'b1});

    // Bounces shorter than the debounce window are ignored.
    cur_edge = 0;
    ext_rst_i = 1'b1; goto_edge(500);
    ext_rst_i = 1'b0; goto_edge(510);
    ext_rst_i = 1'b1; goto_edge(1533);
    ext_rst_i = 1'b0; goto_edge(1553);
    check("bounce_rst_n", {rst_n_a, done_a}, {3'b111, 1'b1});
    check("bounce_cause", cause_a, 4'b0000);

    // A stable assertion resets everything 2+1024+1 edges later.
    cur_edge = 0;
    ext_rst_i = 1'b1;
    goto_edge(1026); check("ext_1026", rst_n_a, 3'b111);
    goto_edge(1027); check("ext_1027", {rst_n_a, done_a}, {3'b000, 1'b0});
    check("ext_cause", cause_a, 4'b0100);

    // Releasing the pin restarts the full hold sequence once it debounces low.
    cur_edge = 0;
    ext_rst_i = 1'b0;
    goto_edge(1282); check("ext_rel_1282", rst_n_a, 3'b000);
    goto_edge(1283); check("ext_rel_1283", rst_n_a, 3'b001);
    goto_edge(1314); check("ext_rel_1314", rst_n_a, 3'b011);
    goto_edge(1315); check("ext_rel_1315", {rst_n_a, done_a}, {3'b111, 1'b1});

    // Software request and clear on the same edge the ext source first fires.
    cur_edge = 0;
    ext_rst_i = 1'b1;
    goto_edge(1026);
    sw_rst_req_i = 1'b1;
    cause_clr_i  = 1'b1;
    goto_edge(1027);
    sw_rst_req_i = 1'b0;
    cause_clr_i  = 1'b0;
    check("simul_cause", cause_a, 4'b1100);
    check("simul_rst_n", rst_n_a, 3'b000);

    // Lock loss while domains are being released.
    @(negedge ref_clk); pad_reset = 1'b1; ext_rst_i = 1'b0;
    repeat (2) @(posedge ref_clk);
    @(negedge ref_clk); pad_reset = 1'b0; cur_edge = 0;
    goto_edge(259); check("lock_pre", rst_n_a, 3'b001);
    locked_i = 1'b0; cur_edge = 0;
    goto_edge(2); check("lock_2", rst_n_a, 3'b001);
    goto_edge(3); check("lock_3", {rst_n_a, done_a}, {3'b000, 1'b0});
    check("lock_cause", cause_a, 4'b0011);
    goto_edge(10);
    locked_i = 1'b1; cur_edge = 0;
    main_release_seq("relock");
    check("relock_cause", cause_a, 4'b0011);

    // pad_reset during RUN acts without a clock edge.
    @(negedge ref_clk); pad_reset = 1'b1;
    #1;
    check("pad_run_rst_n", {rst_n_a, done_a}, {3'b000, 1'b0});
    check("pad_run_cause", cause_a, 4'b0001);

    // pad_reset during HOLD, observed through the cause register.
    @(negedge ref_clk); pad_reset = 1'b0; cur_edge = 0;
    goto_edge(100);
    cause_clr_i = 1'b1;
    goto_edge(101);
    cause_clr_i = 1'b0;
    check("hold_clr", cause_a, 4'b0000);
    @(negedge ref_clk); pad_reset = 1'b1;
    #1;
    check("pad_hold_cause", cause_a, 4'b0001);
    check("pad_hold_rst_n", rst_n_a, 3'b000);

    // Release timing for all three builds after the mid-sequence reset.
    @(negedge ref_clk); pad_reset = 1'b0; cur_edge = 0;
    goto_edge(6);  check("n8_6", rst_n_c, 8'h00);
    goto_edge(7);  check("n8_7", rst_n_c, 8'h01);
    goto_edge(10); check("n8_10", rst_n_c, 8'h03);
    goto_edge(11); check("n1_11", {rst_n_b, done_b}, 2'b00);
    goto_edge(12); check("n1_12", {rst_n_b, done_b}, 2'b11);
    goto_edge(27); check("n8_27", {rst_n_c, done_c}, {8'h7F, 1'b0});
    goto_edge(28); check("n8_28", {rst_n_c, done_c}, {8'hFF, 1'b1});
    main_release_seq("post_pad");
    check("post_pad_causes", {cause_a, cause_b, cause_c}, 12'h111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulpemu_rst_gen.md
# pulpemu_rst_gen

Parametrised reset generator for the FPGA emulation top level. It replaces the plain inversion of the board reset button with a sequenced reset scheme: it combines the board reset, clock-generator lock, a debounced external reset pin and a software/debug reset request. It releases `NUM_RST` active-low reset domains (SoC, cluster, peripherals, …) in a staggered order and records the cause of the last reset. It sits between the clock buffer/MMCM and the `pulp` instance, driving its reset pads.

## Interface
- `NUM_RST`, 3: number of reset domains; range 1–8.
- `SYNC_STAGES`, 2: synchroniser depth for `locked_i` and `ext_rst_i`; at least 2.
- `DEBOUNCE_CYCLES`, 1024: cycles `ext_rst_i` must be stable before its debounced value changes; at least 1.
- `HOLD_CYCLES`, 256: minimum reset hold after all sources clear; at least 1.
- `STAGGER_CYCLES`, 16: delay between consecutive domain releases; at least 1.

Ports:
- `ref_clk`  in  1  single clock; all logic is on its rising edge.
- `pad_reset`  in  1  asynchronous, active-high reset. It is the board reset button.
- `locked_i`  in  1  MMCM/PLL lock; asynchronous, synchronised internally.
- `ext_rst_i`  in  1  noisy external reset pin, active-high; asynchronous, synchronised and debounced.
- `sw_rst_req_i`  in  1  single-cycle synchronous reset request from debug/SoC logic.
- `cause_clr_i`  in  1  single-cycle synchronous clear of `rst_cause_o`.
- `rst_n_o`  out  NUM_RST  per-domain active-low reset; bit 0 is released first.
- `rst_done_o`  out  1  high when all domains are released.
- `rst_cause_o`  out  4  sticky cause flags: [0] pad, [1] lock loss, [2] ext, [3] sw.

## Operation
- **Reset values while `pad_reset` is high:**
  - `rst_n_o` = all 0.
  - `rst_done_o` = 0.
  - `rst_cause_o` = 4'b0001.
  - Synchroniser flops, the debounced ext value and all counters = 0.
  - State = WAIT_LOCK.
- **Synchronisers:** `lock_s` and `ext_s` are each `SYNC_STAGES` flops.
- **Debounce:**
  - A counter increments while `ext_s` differs from `ext_db` and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, `ext_db` takes the value of `ext_s` and the counter clears.
  - The counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It never wraps.
- **Reset event** is `(!lock_s) | ext_db | sw_rst_req_i`. `sw_rst_req_i` counts only for its one cycle.
- **FSM:**
  - WAIT_LOCK: stay while the event is true. Otherwise clear the counter and go to HOLD.
  - HOLD: count `HOLD_CYCLES` cycles. An event returns the FSM to WAIT_LOCK, which restarts the hold. At terminal count, set channel index 0, deassert `rst_n_o[0]`, and go to RELEASE.
  - RELEASE: every `STAGGER_CYCLES` cycles, release the next channel. When channel `NUM_RST-1` is released, go to RUN and set `rst_done_o`.
  - RUN: stay until an event.
  - In RELEASE or RUN, an event moves the FSM to WAIT_LOCK. On the next edge, all `rst_n_o` are 0 and `rst_done_o` is 0.
- **Outputs:**
  - `rst_n_o` is registered. A bit, once released, stays high until the next event or `pad_reset`.
  - Assertion is synchronous to `ref_clk`, except under `pad_reset`, where it is asynchronous.
- **Cause flags:**
  - Each flag is set on the cycle its source contributes to an event in any state other than WAIT_LOCK. The exception is lock loss, which is also flagged in WAIT_LOCK.
  - Simultaneous sources set several bits.
  - `cause_clr_i` clears all bits. A set on the same cycle wins over the clear.
- **Special cases:**
  - With `NUM_RST`=1, RELEASE lasts zero cycles: HOLD goes directly to RUN, and `rst_done_o` rises with `rst_n_o[0]`.
  - `sw_rst_req_i` held high for several cycles behaves like repeated requests.

## Timing
- Cycle counts are in `ref_clk` rising edges. Edge 1 is the first edge with `pad_reset` low. `locked_i` is high and `ext_rst_i` is low throughout.
- First release: `rst_n_o[0]` rises at edge `SYNC_STAGES + HOLD_CYCLES + 1`.
- Later releases: `rst_n_o[i]` rises `i*STAGGER_CYCLES` edges after `rst_n_o[0]`.
- `rst_done_o` rises on the same edge as `rst_n_o[NUM_RST-1]`.
- `sw_rst_req_i` sampled at edge k forces `rst_n_o` to 0 at edge k+1. The next `rst_n_o[0]` release is at k + 1 + `HOLD_CYCLES` + 1.
- Latency from `ext_rst_i` rising to `rst_n_o` falling is `SYNC_STAGES + DEBOUNCE_CYCLES + 1` edges.
- Lock loss reaches `rst_n_o` after `SYNC_STAGES + 1` edges.
- Release after a lock or ext event restarts the full hold sequence once the source clears.

## Test plan
- **Power-on, defaults:** drop `pad_reset`, `locked_i`=1.
  - `rst_n_o` = 3'b001 at edge 259, 3'b011 at edge 275, 3'b111 at edge 291.
  - `rst_done_o` rises at edge 291. `rst_cause_o` = 4'b0001.
- **Software request in RUN:** one-cycle `sw_rst_req_i` at edge k.
  - `rst_n_o` = 0 and `rst_done_o` = 0 at k+1.
  - `rst_n_o[0]` high at k+258.
  - `rst_cause_o` = 4'b1001. Then pulse `cause_clr_i` → 4'b0000.
- **Bounce rejection:** toggle `ext_rst_i` high for 500 cycles, low for 10, high for 1023 → no reset. Hold it high for 1024 stable cycles → all `rst_n_o` fall 2+1024+1 edges after the final rising edge; bit [2] is set.
- **Lock loss during RELEASE:** drop `locked_i` after `rst_n_o` = 3'b001.
  - All outputs are 0 three edges later.
  - Restore lock → the full sequence repeats from HOLD.
  - `rst_cause_o` = 4'b0011.
- **Simultaneous events and clear:** `sw_rst_req_i` and `cause_clr_i` together while the ext source is active → bits [3] and [2] set; the clear is ignored for bits being set.
- **Mid-sequence `pad_reset`:** assert during HOLD and during RUN → `rst_n_o` = 0 asynchronously, without waiting for a clock. After release, `NUM_RST`=1 and `NUM_RST`=8 builds meet the release-timing formulas.
